// File: rtl/mold_pkt_gen.sv
// MoldUDP-style packet generator: streams header + length-prefixed messages
// over AXI-Stream, one run of pkt_cnt packets per start request.
module mold_pkt_gen #(
    parameter int              AXI_DATA_W  = 64,
    parameter int              AXI_KEEP_W  = AXI_DATA_W / 8,
    parameter int              SID_W       = 80,
    parameter int              SEQ_NUM_W   = 64,
    parameter int              ML_W        = 16,
    parameter logic [ML_W-1:0] EOS_MSG_CNT = 16'hffff,
    parameter int              IPG         = 2
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  start_i,
    input  logic [SID_W-1:0]      sid_i,
    input  logic [SEQ_NUM_W-1:0]  seq_num_i,
    input  logic [ML_W-1:0]       msg_cnt_i,
    input  logic [ML_W-1:0]       msg_len_i,
    input  logic [15:0]           pkt_cnt_i,
    input  logic                  eos_i,
    output logic                  udp_axis_tvalid_o,
    output logic [AXI_DATA_W-1:0] udp_axis_tdata_o,
    output logic [AXI_KEEP_W-1:0] udp_axis_tkeep_o,
    output logic                  udp_axis_tlast_o,
    output logic                  udp_axis_tuser_o,
    input  logic                  udp_axis_tready_i,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int             HDR_W    = ML_W + SEQ_NUM_W + SID_W;
    localparam logic [7:0]     HDR_B    = 8'(HDR_W / 8);
    localparam logic [ML_W:0]  LEN_B    = (ML_W + 1)'(ML_W / 8);
    localparam logic [15:0]    IPG_LAST = 16'(IPG - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_GAP, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [SID_W-1:0]      sid_q, sid_d;
    logic [SEQ_NUM_W-1:0]  seq_q, seq_d;
    logic [ML_W-1:0]       cnt_q, cnt_d;
    logic [ML_W-1:0]       nmsg_q, nmsg_d;
    logic [ML_W-1:0]       len_q, len_d;
    logic [15:0]           pkt_left_q, pkt_left_d;
    logic [7:0]            hdr_pos_q, hdr_pos_d;
    logic [ML_W-1:0]       m_idx_q, m_idx_d;
    logic [ML_W:0]         m_off_q, m_off_d;
    logic [15:0]           gap_q, gap_d;

    logic [HDR_W-1:0]      hdr_vec;
    logic [ML_W:0]         rec_last;
    logic [7:0]            walk_hdr;
    logic [ML_W-1:0]       walk_idx;
    logic [ML_W:0]         walk_off;
    logic [AXI_DATA_W-1:0] beat_data;
    logic [AXI_KEEP_W-1:0] beat_keep;
    logic                  beat_last;

    assign hdr_vec  = {cnt_q, seq_q, sid_q};
    assign rec_last = {1'b0, len_q} + LEN_B - (ML_W + 1)'(1);

    // Walk the byte stream lane by lane from the position saved at the start of this beat;
    // the walker's end position becomes the next beat's start position.
    always_comb begin
        walk_hdr  = hdr_pos_q;
        walk_idx  = m_idx_q;
        walk_off  = m_off_q;
        beat_data = '0;
        beat_keep = '0;
        for (int i = 0; i < AXI_KEEP_W; i++) begin
            if (walk_hdr < HDR_B) begin
                beat_data[8*i +: 8] = 8'(hdr_vec >> (8 * walk_hdr));
                beat_keep[i]        = 1'b1;
                walk_hdr            = walk_hdr + 8'd1;
            end else if (walk_idx < nmsg_q) begin
                if (walk_off < LEN_B) begin
                    beat_data[8*i +: 8] = 8'(len_q >> (8 * walk_off));
                end else begin
                    beat_data[8*i +: 8] = walk_idx[7:0] + 8'hA0;
                end
                beat_keep[i] = 1'b1;
                if (walk_off == rec_last) begin
                    walk_off = '0;
                    walk_idx = walk_idx + 1'b1;
                end else begin
                    walk_off = walk_off + 1'b1;
                end
            end
        end
        beat_last = (walk_hdr == HDR_B) && (walk_idx == nmsg_q);
    end

    always_comb begin
        state_d    = state_q;
        sid_d      = sid_q;
        seq_d      = seq_q;
        cnt_d      = cnt_q;
        nmsg_d     = nmsg_q;
        len_d      = len_q;
        pkt_left_d = pkt_left_q;
        hdr_pos_d  = hdr_pos_q;
        m_idx_d    = m_idx_q;
        m_off_d    = m_off_q;
        gap_d      = gap_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    sid_d      = sid_i;
                    seq_d      = seq_num_i;
                    cnt_d      = eos_i ? EOS_MSG_CNT : msg_cnt_i;
                    nmsg_d     = eos_i ? '0 : msg_cnt_i;
                    len_d      = msg_len_i;
                    pkt_left_d = (pkt_cnt_i == 16'd0) ? 16'd1 : pkt_cnt_i;
                    hdr_pos_d  = '0;
                    m_idx_d    = '0;
                    m_off_d    = '0;
                    state_d    = S_STREAM;
                end
            end
            S_STREAM: begin
                if (udp_axis_tready_i) begin
                    if (beat_last) begin
                        hdr_pos_d  = '0;
                        m_idx_d    = '0;
                        m_off_d    = '0;
                        gap_d      = '0;
                        seq_d      = seq_q + SEQ_NUM_W'(nmsg_q);
                        pkt_left_d = pkt_left_q - 16'd1;
                        if (pkt_left_q == 16'd1) begin
                            state_d = S_DONE;
                        end else if (IPG == 0) begin
                            state_d = S_STREAM;
                        end else begin
                            state_d = S_GAP;
                        end
                    end else begin
                        hdr_pos_d = walk_hdr;
                        m_idx_d   = walk_idx;
                        m_off_d   = walk_off;
                    end
                end
            end
            S_GAP: begin
                if (gap_q == IPG_LAST) begin
                    state_d = S_STREAM;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q    <= S_IDLE;
            sid_q      <= '0;
            seq_q      <= '0;
            cnt_q      <= '0;
            nmsg_q     <= '0;
            len_q      <= '0;
            pkt_left_q <= '0;
            hdr_pos_q  <= '0;
            m_idx_q    <= '0;
            m_off_q    <= '0;
            gap_q      <= '0;
        end else begin
            state_q    <= state_d;
            sid_q      <= sid_d;
            seq_q      <= seq_d;
            cnt_q      <= cnt_d;
            nmsg_q     <= nmsg_d;
            len_q      <= len_d;
            pkt_left_q <= pkt_left_d;
            hdr_pos_q  <= hdr_pos_d;
            m_idx_q    <= m_idx_d;
            m_off_q    <= m_off_d;
            gap_q      <= gap_d;
        end
    end

    // Beat contents depend only on registered state, so they hold while tready is low.
    assign udp_axis_tvalid_o = (state_q == S_STREAM);
    assign udp_axis_tdata_o  = udp_axis_tvalid_o ? beat_data : '0;
    assign udp_axis_tkeep_o  = udp_axis_tvalid_o ? beat_keep : '0;
    assign udp_axis_tlast_o  = udp_axis_tvalid_o & beat_last;
    assign udp_axis_tuser_o  = 1'b0;
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = (state_q == S_DONE);

endmodule

// File: tb/tb_mold_pkt_gen.sv
// Scoreboard bench for mold_pkt_gen: stimulus queues expected beats, a monitor
// pops and compares on every handshake and records per-packet statistics.
module tb_mold_pkt_gen;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start_i;
    logic [79:0] sid_i;
    logic [63:0] seq_num_i;
    logic [15:0] msg_cnt_i;
    logic [15:0] msg_len_i;
    logic [15:0] pkt_cnt_i;
    logic        eos_i;
    logic        tvalid, tlast, tuser, busy, done;
    logic [63:0] tdata;
    logic [7:0]  tkeep;
    logic        tready;

    always #5 clk = ~clk;

    mold_pkt_gen dut (
        .clk               (clk),
        .nreset            (nreset),
        .start_i           (start_i),
        .sid_i             (sid_i),
        .seq_num_i         (seq_num_i),
        .msg_cnt_i         (msg_cnt_i),
        .msg_len_i         (msg_len_i),
        .pkt_cnt_i         (pkt_cnt_i),
        .eos_i             (eos_i),
        .udp_axis_tvalid_o (tvalid),
        .udp_axis_tdata_o  (tdata),
        .udp_axis_tkeep_o  (tkeep),
        .udp_axis_tlast_o  (tlast),
        .udp_axis_tuser_o  (tuser),
        .udp_axis_tready_i (tready),
        .busy_o            (busy),
        .done_o            (done)
    );

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          start_cyc = 0;
    int          beats_total = 0;
    int          dones = 0;
    int          done_cyc = 0;
    int          bidx = 0;
    bit          new_pkt = 1'b1;
    bit          stall_prev = 1'b0;
    bit          rnd_tready = 1'b0;
    beat_t       held;
    logic [63:0] b1_q[$];
    logic [63:0] b2_q[$];
    int          pbeats_q[$];
    logic [7:0]  lkeep_q[$];
    int          fv_q[$];
    int          lc_q[$];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        beats_total = 0;
        b1_q.delete();
        b2_q.delete();
        pbeats_q.delete();
        lkeep_q.delete();
        fv_q.delete();
        lc_q.delete();
    endtask

    function automatic logic [63:0] hdr_seq(input int p);
        return {b2_q[p][15:0], b1_q[p][63:16]};
    endfunction

    task automatic push_pkt(input logic [79:0] sid, input logic [63:0] seq,
                            input logic [15:0] cf, input int nm, input int len);
        logic [7:0]   by[$];
        logic [159:0] hdr;
        logic [15:0]  lenv;
        beat_t        b;
        int           nb;
        hdr  = {cf, seq, sid};
        lenv = 16'(len);
        for (int i = 0; i < 20; i++) by.push_back(hdr[8*i +: 8]);
        for (int m = 0; m < nm; m++) begin
            by.push_back(lenv[7:0]);
            by.push_back(lenv[15:8]);
            for (int j = 0; j < len; j++) by.push_back(8'(m + 160));
        end
        nb = (by.size() + 7) / 8;
        for (int k = 0; k < nb; k++) begin
            b = '0;
            for (int l = 0; l < 8; l++) begin
                if (k * 8 + l < by.size()) begin
                    b.data[8*l +: 8] = by[k*8 + l];
                    b.keep[l]        = 1'b1;
                end
            end
            b.last = (k == nb - 1);
            exp_q.push_back(b);
        end
    endtask

    task automatic expect_run(input logic [79:0] sid, input logic [63:0] seq, input int cnt,
                              input int len, input int pkts, input bit eos);
        int          n;
        int          nm;
        logic [15:0] cf;
        logic [63:0] s;
        n  = (pkts == 0) ? 1 : pkts;
        nm = eos ? 0 : cnt;
        cf = eos ? 16'hffff : 16'(cnt);
        s  = seq;
        for (int p = 0; p < n; p++) begin
            push_pkt(sid, s, cf, nm, len);
            s = s + 64'(nm);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after a rising edge.
    task automatic run(input logic [79:0] sid, input logic [63:0] seq, input int cnt,
                       input int len, input int pkts, input bit eos);
        int d0;
        int n;
        d0        = dones;
        sid_i     = sid;
        seq_num_i = seq;
        msg_cnt_i = 16'(cnt);
        msg_len_i = 16'(len);
        pkt_cnt_i = 16'(pkts);
        eos_i     = eos;
        expect_run(sid, seq, cnt, len, pkts, eos);
        start_i = 1'b1;
        @(posedge clk);
        start_cyc = cyc;
        #1;
        start_i   = 1'b0;
        sid_i     = ~sid;
        seq_num_i = seq + 64'd100;
        msg_cnt_i = 16'(cnt + 1);
        msg_len_i = 16'(len + 3);
        pkt_cnt_i = 16'd7;
        eos_i     = ~eos;
        @(posedge clk);
        #1 start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (dones == d0 && n < 4000) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 128'(dones != d0), 128'(1));
        repeat (2) @(posedge clk);
        #1;
        chk("queue_drained", 128'(exp_q.size()), 128'(0));
        chk("busy_idle", 128'(busy), 128'(0));
    endtask

    initial begin : tready_drv
        tready = 1'b1;
        forever begin
            @(posedge clk);
            #1 tready = rnd_tready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : monitor
        beat_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (!nreset) begin
                chk("reset_outputs", 128'({tvalid, tlast, tuser, busy, done, tkeep, tdata}), 128'(0));
                bidx       = 0;
                new_pkt    = 1'b1;
                stall_prev = 1'b0;
            end else begin
                if (tvalid) begin
                    if (new_pkt) begin
                        fv_q.push_back(cyc);
                        new_pkt = 1'b0;
                    end
                    if (stall_prev)
                        chk("stall_stable", 128'({held.data, held.keep, held.last}),
                            128'({tdata, tkeep, tlast}));
                    if (tready) begin
                        chk("tuser", 128'(tuser), 128'(0));
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_beat: got data %0h, expected no beat", tdata);
                        end else begin
                            e = exp_q.pop_front();
                            chk("beat_data", 128'(tdata), 128'(e.data));
                            chk("beat_keep", 128'(tkeep), 128'(e.keep));
                            chk("beat_last", 128'(tlast), 128'(e.last));
                        end
                        beats_total++;
                        if (bidx == 1) b1_q.push_back(tdata);
                        if (bidx == 2) b2_q.push_back(tdata);
                        if (tlast) begin
                            pbeats_q.push_back(bidx + 1);
                            lkeep_q.push_back(tkeep);
                            lc_q.push_back(cyc);
                            bidx    = 0;
                            new_pkt = 1'b1;
                        end else begin
                            bidx++;
                        end
                        stall_prev = 1'b0;
                    end else begin
                        held       = '{data: tdata, keep: tkeep, last: tlast};
                        stall_prev = 1'b1;
                    end
                end else begin
                    stall_prev = 1'b0;
                end
                if (done) begin
                    dones++;
                    done_cyc = cyc;
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        int d0;
        int n;
        nreset    = 1'b0;
        start_i   = 1'b0;
        sid_i     = '0;
        seq_num_i = '0;
        msg_cnt_i = '0;
        msg_len_i = '0;
        pkt_cnt_i = '0;
        eos_i     = 1'b0;
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;

        // 3 messages of 16 bytes, started on the first cycle out of reset
        clear_stats();
        run(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 3, 16, 1, 1'b0);
        chk("a_pkts", 128'(pbeats_q.size()), 128'(1));
        chk("a_beats", 128'(pbeats_q[0]), 128'(10));
        chk("a_beat2", 128'(b2_q[0]), 128'(64'hA0A0_0010_0003_F0F0));
        chk("a_lastkeep", 128'(lkeep_q[0]), 128'(8'h03));
        chk("a_latency", 128'(fv_q[0]), 128'(start_cyc + 1));

        // heartbeat, two packets
        clear_stats();
        run(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 0, 16, 2, 1'b0);
        chk("hb_pkts", 128'(pbeats_q.size()), 128'(2));
        chk("hb_beats0", 128'(pbeats_q[0]), 128'(3));
        chk("hb_beats1", 128'(pbeats_q[1]), 128'(3));
        chk("hb_lastkeep", 128'(lkeep_q[1]), 128'(8'h0F));
        chk("hb_seq0", 128'(hdr_seq(0)), 128'(64'hF0F0F0F0F0F0F0F0));
        chk("hb_seq1", 128'(hdr_seq(1)), 128'(64'hF0F0F0F0F0F0F0F0));
        chk("hb_gap", 128'(fv_q[1] - lc_q[0] - 1), 128'(2));

        // three packets, sequence advance and done timing
        clear_stats();
        d0 = dones;
        run(80'h1234, 64'd5, 2, 4, 3, 1'b0);
        chk("c_seq0", 128'(hdr_seq(0)), 128'(64'd5));
        chk("c_seq1", 128'(hdr_seq(1)), 128'(64'd7));
        chk("c_seq2", 128'(hdr_seq(2)), 128'(64'd9));
        chk("c_beats", 128'(pbeats_q[2]), 128'(4));
        chk("c_lastkeep", 128'(lkeep_q[2]), 128'(8'hFF));
        chk("c_done_once", 128'(dones - d0), 128'(1));
        chk("c_done_time", 128'(done_cyc), 128'(lc_q[2] + 1));

        // random backpressure, same packet as the first run
        clear_stats();
        rnd_tready = 1'b1;
        run(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 3, 16, 1, 1'b0);
        rnd_tready = 1'b0;
        chk("bp_beats", 128'(pbeats_q[0]), 128'(10));
        chk("bp_beat2", 128'(b2_q[0]), 128'(64'hA0A0_0010_0003_F0F0));

        // end of session
        clear_stats();
        run(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 5, 16, 1, 1'b1);
        chk("eos_pkts", 128'(pbeats_q.size()), 128'(1));
        chk("eos_beats", 128'(pbeats_q[0]), 128'(3));
        chk("eos_cnt", 128'(b2_q[0][31:16]), 128'(16'hFFFF));
        chk("eos_lastkeep", 128'(lkeep_q[0]), 128'(8'h0F));

        // pkt_cnt 0 treated as 1, zero-length messages
        clear_stats();
        run(80'h55, 64'h0123456789ABCDEF, 2, 0, 0, 1'b0);
        chk("z_pkts", 128'(pbeats_q.size()), 128'(1));
        chk("z_beats", 128'(pbeats_q[0]), 128'(3));
        chk("z_beat2", 128'(b2_q[0]), 128'(64'h0000_0000_0002_0123));
        chk("z_lastkeep", 128'(lkeep_q[0]), 128'(8'hFF));

        // sequence wraps modulo 2^64
        clear_stats();
        run(80'h77, 64'hFFFFFFFFFFFFFFFF, 1, 1, 2, 1'b0);
        chk("w_seq0", 128'(hdr_seq(0)), 128'(64'hFFFFFFFFFFFFFFFF));
        chk("w_seq1", 128'(hdr_seq(1)), 128'(64'd0));

        // reset in the middle of a packet, then a fresh run
        clear_stats();
        sid_i     = 80'hDEADBEEF;
        seq_num_i = 64'hF0F0F0F0F0F0F0F0;
        msg_cnt_i = 16'd3;
        msg_len_i = 16'd16;
        pkt_cnt_i = 16'd1;
        eos_i     = 1'b0;
        expect_run(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 3, 16, 1, 1'b0);
        start_i = 1'b1;
        @(posedge clk);
        #1 start_i = 1'b0;
        n = 0;
        while (beats_total < 4 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("r_reached_beat4", 128'(beats_total), 128'(4));
        #2 nreset = 1'b0;
        exp_q.delete();
        clear_stats();
        repeat (3) @(posedge clk);
        #1 nreset = 1'b1;
        run(80'hDEADBEEF, 64'hF0F0F0F0F0F0F0F0, 3, 16, 1, 1'b0);
        chk("r_pkts", 128'(pbeats_q.size()), 128'(1));
        chk("r_beats", 128'(pbeats_q[0]), 128'(10));
        chk("r_beat2", 128'(b2_q[0]), 128'(64'hA0A0_0010_0003_F0F0));
        chk("r_latency", 128'(fv_q[0]), 128'(start_cyc + 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mold_pkt_gen.md
MOLD_PKT_GEN -- requirements
Module: mold_pkt_gen

Interface
REQ-001 SHALL have parameter AXI_DATA_W, default 64, stream data width in bits; legal values are multiples of 64.
REQ-002 SHALL have parameter AXI_KEEP_W, default AXI_DATA_W/8, byte-enable width.
REQ-003 SHALL have parameters SID_W 80, SEQ_NUM_W 64, ML_W 16: session id, sequence number and length/count field widths.
REQ-004 SHALL have parameter EOS_MSG_CNT, default 16'hffff, the end-of-session message count value.
REQ-005 SHALL have parameter IPG, default 2, the number of idle cycles (tvalid low) between packets of one run.
REQ-006 SHALL have ports clk, in, 1, the only clock; nreset, in, 1, reset that is asynchronous and active-low.
REQ-007 SHALL have ports start_i, in, 1, run request, sampled only in IDLE.
REQ-008 SHALL have ports sid_i, in, SID_W, and seq_num_i, in, SEQ_NUM_W: session id and first sequence number.
REQ-009 SHALL have ports msg_cnt_i, in, ML_W, messages per packet; msg_len_i, in, ML_W, payload bytes per message; pkt_cnt_i, in, 16, packets per run; eos_i, in, 1, end-of-session run.
REQ-010 SHALL have outputs udp_axis_tvalid_o, 1; udp_axis_tdata_o, AXI_DATA_W; udp_axis_tkeep_o, AXI_KEEP_W; udp_axis_tlast_o, 1; udp_axis_tuser_o, 1; and input udp_axis_tready_i, 1.
REQ-011 SHALL have outputs busy_o, 1, run in progress; done_o, 1, one-cycle run-complete pulse.

Function
REQ-012 SHALL register sid_i, seq_num_i, msg_cnt_i, msg_len_i, pkt_cnt_i and eos_i on the cycle start_i is high in IDLE; later input changes SHALL have no effect until the next run.
REQ-013 SHALL implement the states IDLE -> STREAM -> (GAP -> STREAM)* -> DONE -> IDLE; DONE SHALL last one cycle and assert done_o.
REQ-014 SHALL treat pkt_cnt_i = 0 as 1.
REQ-015 SHALL emit each packet as a byte stream: header H = {msg_cnt, seq_num, sid} (160 bits), then per message {payload, len}, with lower bits first; beat k SHALL carry stream bits [AXI_DATA_W*(k+1)-1 : AXI_DATA_W*k].
REQ-016 SHALL make payload byte j of message m (0-based, within the packet) equal (m + 8'hA0) mod 256, independent of j.
REQ-017 SHALL set the total packet length to 20 + msg_cnt*(2+msg_len) bytes; msg_len 0 SHALL produce length-only messages.
REQ-018 SHALL make the header msg_cnt field equal to EOS_MSG_CNT, and carry no messages, when eos is set; msg_cnt 0 SHALL produce a heartbeat (header only).
REQ-019 SHALL assert tkeep all-ones on non-last beats and lanes 0..r-1 only on the last beat (r = remaining bytes); bytes outside tkeep SHALL be 0.
REQ-020 SHALL assert tlast on the final beat of each packet only; tuser SHALL be 0.
REQ-021 SHALL, once tvalid rises, hold tvalid, tdata, tkeep and tlast stable until the cycle tvalid & tready; a beat SHALL advance only on that cycle.
REQ-022 SHALL present the first beat one cycle after start_i is accepted.
REQ-023 SHALL advance the sequence number by msg_cnt after each packet, modulo 2^SEQ_NUM_W; heartbeat and EOS packets SHALL NOT advance it.
REQ-024 SHALL hold tvalid low for exactly IPG cycles in GAP (IPG 0 skips GAP) and enter DONE after the last packet's tlast handshake.
REQ-025 SHALL ignore start_i while busy_o is high; busy_o SHALL be high in STREAM, GAP and DONE.

Reset
REQ-026 SHALL, on nreset low, immediately return to IDLE and drive tvalid, tlast, tuser, busy_o and done_o to 0, and tdata and tkeep to 0; a packet interrupted mid-stream SHALL NOT resume.
REQ-027 SHALL accept start_i on the first cycle after nreset deasserts.

Verification
REQ-028 SHALL pass this test: sid 80'hDEADBEEF, seq 64'hF0F0F0F0F0F0F0F0, msg_cnt 3, msg_len 16, tready 1 -> 74 bytes in 10 beats; beat2 = {16'hA0A0, 16'd16, H[159:128]}; last keep 8'b00000011 with tlast.
REQ-029 SHALL pass this test: heartbeat with msg_cnt 0, pkt_cnt 2 -> two 3-beat packets, last keep 8'h0F, both with seq F0F0F0F0F0F0F0F0, and 2 idle cycles between them.
REQ-030 SHALL pass this test: pkt_cnt 3, msg_cnt 2, seq 5 -> header seq 5, 7, 9; done_o pulses once, 1 cycle after the third tlast.
REQ-031 SHALL pass this test: random tready deassertion -> payload bit-identical to the tready=1 run; tdata, tkeep and tlast stable whenever tvalid & !tready.
REQ-032 SHALL pass this test: eos 1 -> one 3-beat packet with msg_cnt field 16'hffff and no messages.
REQ-033 SHALL pass this test: nreset pulsed at beat 4, then start_i -> all outputs 0 during reset, then a complete, fresh packet from beat 0.
